lcd_digit_renderer: RTL

//  Renders one 16x8 decimal digit glyph onto the LCD as a stream of RGB565 pixels.

---
 rtl/lcd_pkg.sv | 33 +++
 rtl/lcd_digit_renderer_if.sv | 29 ++
 rtl/lcd_row_serializer.sv | 51 +++++
 rtl/lcd_digit_renderer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD digit renderer.
// Contents:
//   DIGIT_ROWS / DIGIT_COLS  glyph geometry (16 rows of 8 pixels)
//   DIGIT_COUNT              number of drawable digits (0..9)
//   DIGIT_ROM_DEPTH          digit ROM depth (DIGIT_COUNT * DIGIT_ROWS)
//   rgb565_t                 16-bit RGB565 pixel type
//   render_state_e           renderer FSM states
//   glyph_addr()             ROM address of one glyph row
package lcd_pkg;

    localparam int DIGIT_ROWS      = 16;
    localparam int DIGIT_COLS      = 8;
    localparam int DIGIT_COUNT     = 10;
    localparam int DIGIT_ROM_DEPTH = DIGIT_COUNT * DIGIT_ROWS;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2
    } render_state_e;

    // digit*16 + row is simply the concatenation of the two nibbles.
    // Digits outside 0..9 have no glyph and park the address at 0.
    function automatic logic [7:0] glyph_addr(input logic [3:0] digit, input logic [3:0] row);
        if (int'(digit) >= DIGIT_COUNT) begin
            return 8'h00;
        end
        return {digit, row};
    endfunction

endpackage

// File: rtl/lcd_digit_renderer_if.sv
// Pixel stream bundle between the digit renderer and the LCD write path.
// Signals:
//   pix_valid  pixel valid (renderer -> LCD)
//   pix_ready  LCD can accept (LCD -> renderer); transfer on valid & ready
//   pix_data   RGB565 pixel
//   pix_x/y    screen coordinates of the pixel
//   pix_last   final (128th) pixel of the glyph
// Modports: master = renderer side, slave = LCD side.
interface lcd_digit_renderer_if #(
    parameter int COORD_W = 9
);
    logic               pix_valid;
    logic               pix_ready;
    logic [15:0]        pix_data;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               pix_last;

    modport master (
        output pix_valid, pix_data, pix_x, pix_y, pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_data, pix_x, pix_y, pix_last,
        output pix_ready
    );

endinterface

// File: rtl/lcd_row_serializer.sv
// Holds one glyph row byte and presents its bits MSB-first.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       capture row_i and restart at column 0
//   row_i        row byte, bit7 = leftmost pixel
//   advance_i    current bit was transferred (valid & ready), step column
//   bit_o        glyph bit of the current column
//   col_o        current column 0..7
//   last_col_o   current column is the rightmost one
module lcd_row_serializer
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] row_i,
    input  logic       advance_i,
    output logic       bit_o,
    output logic [2:0] col_o,
    output logic       last_col_o
);

    logic [7:0] buf_q, buf_d;
    logic [2:0] col_q, col_d;

    always_comb begin
        buf_d = buf_q;
        col_d = col_q;
        if (load_i) begin
            buf_d = row_i;
            col_d = 3'd0;
        end else if (advance_i) begin
            col_d = col_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= 8'h00;
            col_q <= 3'd0;
        end else begin
            buf_q <= buf_d;
            col_q <= col_d;
        end
    end

    assign bit_o      = buf_q[3'd7 - col_q];
    assign col_o      = col_q;
    assign last_col_o = (col_q == 3'(DIGIT_COLS - 1));

endmodule

// File: rtl/lcd_digit_renderer.sv
// Renders one 16x8 decimal digit glyph as a stream of RGB565 pixels.
// A request (start/digit/x_pos/y_pos) is latched while idle; each of the 16
// rows is fetched from the digit ROM (addr = digit*16 + row) and then shifted
// out MSB-first as foreground/background pixels with screen coordinates.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request, accepted only while busy == 0
//   digit, x_pos/y_pos glyph and top-left position, latched on accept
//   invert             (LCD_DIGIT_INVERT_EN only) swap colours for the glyph
//   busy               glyph in progress
//   done               one-cycle pulse after the final pixel transfer
//   rom_addr/rom_data  digit ROM read port, data valid ROM_LAT cycles after addr
//   pix                pixel stream (lcd_digit_renderer_if.master)
// Optional feature macro: LCD_DIGIT_INVERT_EN (adds the invert input).
module lcd_digit_renderer
    import lcd_pkg::*;
#(
    parameter rgb565_t FG_COLOR = 16'hFFFF,
    parameter rgb565_t BG_COLOR = 16'h0000,
    parameter int      ROM_LAT  = 1,
    parameter int      COORD_W  = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         digit,
    input  logic [COORD_W-1:0] x_pos,
    input  logic [COORD_W-1:0] y_pos,
`ifdef LCD_DIGIT_INVERT_EN
    input  logic               invert,
`endif
    output logic               busy,
    output logic               done,
    output logic [7:0]         rom_addr,
    input  logic [7:0]         rom_data,
    lcd_digit_renderer_if.master pix
);

    render_state_e      state_q, state_d;
    logic [3:0]         digit_q, digit_d;
    logic [COORD_W-1:0] x_base_q, x_base_d;
    logic [COORD_W-1:0] y_base_q, y_base_d;
    logic [3:0]         row_q, row_d;
    logic [1:0]         lat_q, lat_d;
    logic [7:0]         addr_q, addr_d;
    logic               done_q, done_d;
    logic               inv_q;
`ifdef LCD_DIGIT_INVERT_EN
    logic               inv_d;
`else
    assign inv_q = 1'b0;
`endif

    logic       ser_load;
    logic       ser_advance;
    logic       ser_bit;
    logic [2:0] ser_col;
    logic       ser_last_col;
    logic       blank;
    logic       valid;
    rgb565_t    fg_eff;
    rgb565_t    bg_eff;

    // Out-of-range digits render as an all-background glyph with identical timing.
    assign blank       = (digit_q >= 4'(DIGIT_COUNT));
    assign valid       = (state_q == SHIFT);
    assign ser_advance = valid & pix.pix_ready;

    lcd_row_serializer u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ser_load),
        .row_i      (blank ? 8'h00 : rom_data),
        .advance_i  (ser_advance),
        .bit_o      (ser_bit),
        .col_o      (ser_col),
        .last_col_o (ser_last_col)
    );

    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        x_base_d = x_base_q;
        y_base_d = y_base_q;
        row_d    = row_q;
        lat_d    = lat_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        ser_load = 1'b0;
`ifdef LCD_DIGIT_INVERT_EN
        inv_d    = inv_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    digit_d  = digit;
                    x_base_d = x_pos;
                    y_base_d = y_pos;
                    row_d    = 4'd0;
                    lat_d    = 2'd0;
                    addr_d   = glyph_addr(digit, 4'd0);
`ifdef LCD_DIGIT_INVERT_EN
                    inv_d    = invert;
`endif
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                // rom_data is sampled on the last of the ROM_LAT address cycles.
                if (lat_q == 2'(ROM_LAT - 1)) begin
                    ser_load = 1'b1;
                    lat_d    = 2'd0;
                    state_d  = SHIFT;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            SHIFT: begin
                if (ser_advance && ser_last_col) begin
                    if (row_q == 4'(DIGIT_ROWS - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        row_d   = row_q + 4'd1;
                        addr_d  = glyph_addr(digit_q, row_q + 4'd1);
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            digit_q  <= 4'd0;
            x_base_q <= '0;
            y_base_q <= '0;
            row_q    <= 4'd0;
            lat_q    <= 2'd0;
            addr_q   <= 8'h00;
            done_q   <= 1'b0;
`ifdef LCD_DIGIT_INVERT_EN
            inv_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            digit_q  <= digit_d;
            x_base_q <= x_base_d;
            y_base_q <= y_base_d;
            row_q    <= row_d;
            lat_q    <= lat_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
`ifdef LCD_DIGIT_INVERT_EN
            inv_q    <= inv_d;
`endif
        end
    end

    assign fg_eff = inv_q ? BG_COLOR : FG_COLOR;
    assign bg_eff = inv_q ? FG_COLOR : BG_COLOR;

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign rom_addr = addr_q;

    // Pixel outputs are driven only from registered state, so they hold
    // steady through a stall; they read as zero whenever no pixel is offered.
    assign pix.pix_valid = valid;
    assign pix.pix_data  = valid ? (ser_bit ? fg_eff : bg_eff) : 16'h0000;
    assign pix.pix_x     = valid ? (x_base_q + COORD_W'(ser_col)) : '0;
    assign pix.pix_y     = valid ? (y_base_q + COORD_W'(row_q)) : '0;
    assign pix.pix_last  = valid & ser_last_col & (row_q == 4'(DIGIT_ROWS - 1));

endmodule
